// File: rtl/hyper_xfer_tracker.sv
// Tracks outstanding hyperbus transfers as a FIFO of direction bits and emits start/done events.
// Optional head-transfer timeout is compiled in only when HYPER_XFER_TIMEOUT_EN is defined.
module hyper_xfer_tracker #(
  parameter int DEPTH = 4,
  parameter int TO_W  = 16
) (
  input  logic                     sys_clk_i,
  input  logic                     rstn_i,
  input  logic                     rx_start_i,
  input  logic                     tx_start_i,
  input  logic                     eot_i,
  input  logic                     clr_i,
  input  logic [TO_W-1:0]          to_limit_i,
  output logic [3:0]               evt_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic                     spur_o,
  output logic                     timeout_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_evt;
  logic          r_ovf;
  logic          r_spur;

  logic          w_empty;
  logic          w_pop;
  logic          w_head;
  logic [CW-1:0] w_free;
  logic          w_push_rx;
  logic          w_push_tx;
  logic          w_drop;
  logic          w_spur;
  logic [PW-1:0] w_tx_ptr;
  logic [CW-1:0] w_count_next;

  // clr_i masks every queue action; the pop is evaluated first so its slot is reusable.
  always_comb begin
    w_empty      = (r_count == '0);
    w_pop        = eot_i && !w_empty && !clr_i;
    w_spur       = eot_i && w_empty && !clr_i;
    w_head       = r_mem[r_rd_ptr];
    w_free       = CW'(DEPTH) - r_count + CW'(w_pop);
    w_push_rx    = rx_start_i && !clr_i && (w_free != '0);
    w_push_tx    = tx_start_i && !clr_i && (w_free > CW'(rx_start_i));
    w_drop       = !clr_i && ((rx_start_i && !w_push_rx) || (tx_start_i && !w_push_tx));
    w_tx_ptr     = r_wr_ptr + PW'(w_push_rx);
    w_count_next = r_count + CW'(w_push_rx) + CW'(w_push_tx) - CW'(w_pop);
  end

  // Storage needs no reset: validity is carried entirely by the pointers and count.
  always_ff @(posedge sys_clk_i) begin
    if (w_push_rx) r_mem[r_wr_ptr] <= 1'b1;
    if (w_push_tx) r_mem[w_tx_ptr] <= 1'b0;
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_evt    <= '0;
      r_ovf    <= 1'b0;
      r_spur   <= 1'b0;
    end else begin
      r_evt <= {w_pop && !w_head, w_pop && w_head, tx_start_i, rx_start_i};
      if (clr_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
        r_spur   <= 1'b0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(w_push_rx) + PW'(w_push_tx);
        r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        r_count  <= w_count_next;
        r_ovf    <= r_ovf | w_drop;
        r_spur   <= r_spur | w_spur;
      end
    end
  end

  assign evt_o     = r_evt;
  assign pending_o = r_count;
  assign busy_o    = !w_empty;
  assign ovf_o     = r_ovf;
  assign spur_o    = r_spur;

`ifdef HYPER_XFER_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // Counter measures how long the current head has been outstanding; it saturates.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (clr_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_pop)
        r_to_cnt <= '0;
      else if (!w_empty && (r_to_cnt != '1))
        r_to_cnt <= r_to_cnt + 1'b1;
      if (!w_empty && (to_limit_i != '0) && (r_to_cnt == to_limit_i))
        r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_to_limit;
  assign w_unused_to_limit = ^to_limit_i;
  assign timeout_o         = 1'b0;
`endif

endmodule

// File: tb/tb_hyper_xfer_tracker.sv
// Directed, table-driven bench for hyper_xfer_tracker (DEPTH=4) plus hand sequences for
// reset and timeout corners; timeout checks follow whether HYPER_XFER_TIMEOUT_EN is defined.
module tb_hyper_xfer_tracker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx, tx, eot, clr;
  logic [15:0] to_limit;
  logic [3:0]  evt;
  logic [2:0]  pending;
  logic        busy, ovf, spur, timeout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rx;
    logic       tx;
    logic       eot;
    logic       clr;
    logic [3:0] evt;
    int         pend;
    logic       ovf;
    logic       spur;
  } vec_t;

  vec_t vq[$];

  hyper_xfer_tracker #(.DEPTH(4), .TO_W(16)) dut (
    .sys_clk_i  (clk),
    .rstn_i     (rstn),
    .rx_start_i (rx),
    .tx_start_i (tx),
    .eot_i      (eot),
    .clr_i      (clr),
    .to_limit_i (to_limit),
    .evt_o      (evt),
    .pending_o  (pending),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .spur_o     (spur),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic a_rx, input logic a_tx, input logic a_eot, input logic a_clr,
                     input logic [3:0] a_evt, input int a_pend, input logic a_ovf, input logic a_spur);
    vec_t v;
    v.rx = a_rx; v.tx = a_tx; v.eot = a_eot; v.clr = a_clr;
    v.evt = a_evt; v.pend = a_pend; v.ovf = a_ovf; v.spur = a_spur;
    vq.push_back(v);
  endtask

  // One clock with the given pulse inputs; returns at posedge+1 with pulses cleared.
  task automatic step(input logic s_rx, input logic s_tx, input logic s_eot, input logic s_clr);
    rx = s_rx; tx = s_tx; eot = s_eot; clr = s_clr;
    @(posedge clk);
    #1;
    rx = 1'b0; tx = 1'b0; eot = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_evt"}, int'(evt), 0);
    chk({tag, "_pend"}, int'(pending), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_spur"}, int'(spur), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    rstn = 1'b0; rx = 1'b0; tx = 1'b0; eot = 1'b0; clr = 1'b0; to_limit = 16'd0;

    // rx then eot 5 cycles later
    add(1,0,0,0, 4'b0001, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0,0,0,0, 4'b0000, 1, 0, 0);
    add(0,0,1,0, 4'b0100, 0, 0, 0);
    add(0,0,0,0, 4'b0000, 0, 0, 0);
    // same-cycle rx+tx: read popped first, then write
    add(1,1,0,0, 4'b0011, 2, 0, 0);
    add(0,0,1,0, 4'b0100, 1, 0, 0);
    add(0,0,1,0, 4'b1000, 0, 0, 0);
    // five tx into depth 4, drain, clear
    for (int i = 1; i <= 4; i++) add(0,1,0,0, 4'b0010, i, 0, 0);
    add(0,1,0,0, 4'b0010, 4, 1, 0);
    for (int i = 3; i >= 0; i--) add(0,0,1,0, 4'b1000, i, 1, 0);
    add(0,0,0,1, 4'b0000, 0, 0, 0);
    // full queue with same-cycle eot+rx; the pushed read comes out last
    for (int i = 1; i <= 4; i++) add(0,1,0,0, 4'b0010, i, 0, 0);
    add(1,0,1,0, 4'b1001, 4, 0, 0);
    for (int i = 3; i >= 1; i--) add(0,0,1,0, 4'b1000, i, 0, 0);
    add(0,0,1,0, 4'b0100, 0, 0, 0);
    // spurious eot, sticky, then cleared
    add(0,0,1,0, 4'b0000, 0, 0, 1);
    add(0,0,0,0, 4'b0000, 0, 0, 1);
    add(0,0,0,1, 4'b0000, 0, 0, 0);
    // clr wins over same-cycle eot and tx, starts still echoed
    add(1,0,0,0, 4'b0001, 1, 0, 0);
    add(0,1,1,1, 4'b0010, 0, 0, 0);
    add(0,0,1,0, 4'b0000, 0, 0, 1);
    add(0,0,0,1, 4'b0000, 0, 0, 0);
    // one free slot, rx+tx: read kept, write dropped
    for (int i = 1; i <= 3; i++) add(0,1,0,0, 4'b0010, i, 0, 0);
    add(1,1,0,0, 4'b0011, 4, 1, 0);
    for (int i = 3; i >= 1; i--) add(0,0,1,0, 4'b1000, i, 1, 0);
    add(0,0,1,0, 4'b0100, 0, 1, 0);
    add(0,0,0,1, 4'b0000, 0, 0, 0);

    #12;
    chk_all_zero("reset_hold");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      rx = vq[i].rx; tx = vq[i].tx; eot = vq[i].eot; clr = vq[i].clr;
      @(posedge clk);
      #1;
      $display("vec %0d: rx=%b tx=%b eot=%b clr=%b -> evt=%b pend=%0d ovf=%b spur=%b",
               i, vq[i].rx, vq[i].tx, vq[i].eot, vq[i].clr, evt, pending, ovf, spur);
      chk($sformatf("v%0d_evt", i), int'(evt), int'(vq[i].evt));
      chk($sformatf("v%0d_pend", i), int'(pending), vq[i].pend);
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vq[i].pend != 0));
      chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vq[i].ovf));
      chk($sformatf("v%0d_spur", i), int'(spur), int'(vq[i].spur));
      chk($sformatf("v%0d_timeout", i), int'(timeout), 0);
    end
    rx = 1'b0; tx = 1'b0; eot = 1'b0; clr = 1'b0;

    // asynchronous reset with three reads outstanding
    for (int i = 0; i < 3; i++) step(1,0,0,0);
    chk("pre_reset_pend", int'(pending), 3);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    $display("mid-op reset: evt=%b pend=%0d", evt, pending);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0);
      chk("post_reset_evt", int'(evt), 0);
      chk("post_reset_pend", int'(pending), 0);
    end
    step(0,0,1,0);
    $display("eot after reset: evt=%b spur=%b", evt, spur);
    chk("post_reset_eot_evt", int'(evt), 0);
    chk("post_reset_eot_spur", int'(spur), 1);
    step(0,0,0,1);

    // push accepted in the first cycle after release
    #2;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    step(1,0,0,0);
    $display("first push after release: evt=%b pend=%0d", evt, pending);
    chk("first_push_evt", int'(evt), 1);
    chk("first_push_pend", int'(pending), 1);
    step(0,0,1,0);
    chk("first_push_done_evt", int'(evt), 4);
    chk("first_push_done_pend", int'(pending), 0);

`ifdef HYPER_XFER_TIMEOUT_EN
    to_limit = 16'd10;
    step(1,0,0,0);
    for (int i = 0; i < 9; i++) step(0,0,0,0);
    $display("timeout after 9 busy cycles: timeout=%b", timeout);
    chk("to_early", int'(timeout), 0);
    step(0,0,0,0);
    step(0,0,0,0);
    $display("timeout after 11 busy cycles: timeout=%b pend=%0d", timeout, pending);
    chk("to_fired", int'(timeout), 1);
    chk("to_pend", int'(pending), 1);
    step(0,0,0,1);
    chk("to_cleared", int'(timeout), 0);
    to_limit = 16'd0;
    step(1,0,0,0);
    for (int i = 0; i < 20; i++) step(0,0,0,0);
    $display("limit 0 after 20 cycles: timeout=%b", timeout);
    chk("to_disabled", int'(timeout), 0);
    step(0,0,0,1);
`else
    to_limit = 16'd10;
    step(1,0,0,0);
    for (int i = 0; i < 15; i++) step(0,0,0,0);
    $display("no timeout build after 15 cycles: timeout=%b pend=%0d", timeout, pending);
    chk("to_absent", int'(timeout), 0);
    chk("to_absent_pend", int'(pending), 1);
    step(0,0,0,1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hyper_xfer_tracker.md
HYPER_XFER_TRACKER -- requirements
Module: hyper_xfer_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4: outstanding-transfer queue depth; power of 2, at least 2.
REQ-002 SHALL have parameter TO_W, default 16: timeout counter width, used only when REQ-030 applies.
REQ-003 SHALL have port sys_clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_start_i, input, 1: one-cycle pulse, RX linear channel enqueued, i.e. a hyperbus read was launched.
REQ-006 SHALL have port tx_start_i, input, 1: one-cycle pulse, TX linear channel enqueued, i.e. a hyperbus write was launched.
REQ-007 SHALL have port eot_i, input, 1: one-cycle end-of-transfer pulse from the hyperbus controller.
REQ-008 SHALL have port clr_i, input, 1: synchronous clear of the queue and the sticky flags.
REQ-009 SHALL have port to_limit_i, input, TO_W: timeout threshold in cycles; 0 disables the timeout.
REQ-010 SHALL have port evt_o, output, 4: registered events; [0] rx start, [1] tx start, [2] read done, [3] write done.
REQ-011 SHALL have port pending_o, output, $clog2(DEPTH)+1: number of outstanding transfers.
REQ-012 SHALL have port busy_o, output, 1: pending_o is non-zero.
REQ-013 SHALL have port ovf_o, output, 1: sticky; a push was lost because the queue was full.
REQ-014 SHALL have port spur_o, output, 1: sticky; eot_i arrived with an empty queue.
REQ-015 SHALL have port timeout_o, output, 1: sticky; the head transfer exceeded to_limit_i.

Function
REQ-016 SHALL keep a FIFO of direction bits (1 = read, 0 = write) using binary read and write pointers that wrap modulo DEPTH.
REQ-017 SHALL push 1 on rx_start_i and push 0 on tx_start_i.
REQ-018 SHALL, when rx_start_i and tx_start_i arrive in the same cycle, push the read entry first and the write entry second, so two slots are consumed.
REQ-019 SHALL, on eot_i with a non-empty queue, pop the head entry and assert evt_o[2] if the entry is a read, or evt_o[3] if it is a write, on the next cycle for exactly one cycle.
REQ-020 SHALL evaluate a pop before pushes within the same cycle, so a full queue accepts one push in a cycle where eot_i is asserted.
REQ-021 SHALL, when free slots are insufficient, keep the pushes that fit in REQ-018 order, drop the remainder, set ovf_o, and leave stored entries untouched.
REQ-022 SHALL, on eot_i with an empty queue, set spur_o and assert neither evt_o[2] nor evt_o[3].
REQ-023 SHALL drive evt_o[0] and evt_o[1] as rx_start_i and tx_start_i delayed by one cycle, whether or not the push succeeded.
REQ-024 SHALL update pending_o and busy_o in the cycle after a push or pop; the arithmetic SHALL be pending + pushes - pop, saturating at 0..DEPTH.
REQ-025 SHALL, on clr_i, empty the queue and clear ovf_o, spur_o and timeout_o on the next edge; clr_i SHALL take priority over same-cycle inputs, while evt_o[0] and evt_o[1] still echo their inputs.

Reset
REQ-026 SHALL, while rstn_i is low, immediately force evt_o=0, pending_o=0, busy_o=0, ovf_o=0, spur_o=0, timeout_o=0, both pointers=0 and the timeout counter=0.
REQ-027 SHALL discard all outstanding entries when reset is asserted mid-operation; no done event SHALL follow release.
REQ-028 SHALL accept a push in the first cycle after rstn_i deasserts.

Configuration
REQ-029 SHALL compile the timeout logic only when macro HYPER_XFER_TIMEOUT_EN is defined.
REQ-030 SHALL, with HYPER_XFER_TIMEOUT_EN defined:
- count cycles while busy_o=1;
- restart the count on every pop, clr_i or reset;
- set timeout_o when the count equals to_limit_i and to_limit_i is non-zero;
- never pop the queue because of a timeout.
REQ-031 SHALL, without HYPER_XFER_TIMEOUT_EN, tie timeout_o to 0, ignore to_limit_i, and instantiate no counter.

Verification
REQ-032 Bench SHALL cover: rx_start pulse, eot 5 cycles later -> evt_o=0001 at +1, pending 1, then evt_o=0100 one cycle after eot, pending 0.
REQ-033 Bench SHALL cover: same-cycle rx+tx start, then two eot pulses -> evt_o[2] on the first, evt_o[3] on the second, pending 2->1->0.
REQ-034 Bench SHALL cover: with DEPTH=4, five tx starts -> pending 4, ovf_o=1; four eot -> four evt_o[3] pulses; clr_i -> ovf_o=0.
REQ-035 Bench SHALL cover: queue full (4) plus eot and rx_start in the same cycle -> head popped, read pushed, pending stays 4, ovf_o stays 0.
REQ-036 Bench SHALL cover: eot on an empty queue -> spur_o=1, evt_o=0000; rstn_i low with 3 pending -> all outputs 0 at once, no later done events.
REQ-037 Bench SHALL cover, with HYPER_XFER_TIMEOUT_EN: to_limit_i=10, one read, no eot -> timeout_o=1 after 10 busy cycles, pending still 1; with to_limit_i=0 -> timeout_o stays 0.
